// File: rtl/rate_pkg.sv
// Shared constants for the tick-rate decoder: default periods, state
// encoding and the 2-bit speed codes.
package rate_pkg;

    localparam int unsigned RATE_W_DEF   = 28;
    localparam int unsigned PERIOD_0_DEF = 2;
    localparam int unsigned PERIOD_1_DEF = 50_000_000;
    localparam int unsigned PERIOD_2_DEF = 100_000_000;
    localparam int unsigned PERIOD_3_DEF = 200_000_000;
    localparam int unsigned TOL_DEF      = 1024;
    localparam int unsigned LOCK_DEF     = 2;
    localparam int unsigned TIMEOUT_DEF  = 250_000_000;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    localparam logic [1:0] RATE_FULL    = 2'b00;
    localparam logic [1:0] RATE_1HZ     = 2'b01;
    localparam logic [1:0] RATE_HALF    = 2'b10;
    localparam logic [1:0] RATE_QUARTER = 2'b11;

endpackage

// File: rtl/rate_classifier.sv
// Combinational match of a measured tick spacing against the four
// nominal periods; the lowest matching code wins.
module rate_classifier
    import rate_pkg::*;
#(
    parameter int unsigned RATE_W   = RATE_W_DEF,
    parameter int unsigned PERIOD_0 = PERIOD_0_DEF,
    parameter int unsigned PERIOD_1 = PERIOD_1_DEF,
    parameter int unsigned PERIOD_2 = PERIOD_2_DEF,
    parameter int unsigned PERIOD_3 = PERIOD_3_DEF,
    parameter int unsigned TOL      = TOL_DEF
) (
    input  logic [RATE_W-1:0] cnt,
    output logic              hit,
    output logic [1:0]        cls
);

    localparam int unsigned DW = RATE_W + 1;

    logic [DW-1:0] cnt_x;
    logic [DW-1:0] tol_x;
    logic [DW-1:0] per  [4];
    logic [DW-1:0] diff [4];
    logic [3:0]    hit_k;

    assign cnt_x  = {1'b0, cnt};
    assign tol_x  = DW'(TOL);
    assign per[0] = DW'(PERIOD_0);
    assign per[1] = DW'(PERIOD_1);
    assign per[2] = DW'(PERIOD_2);
    assign per[3] = DW'(PERIOD_3);

    // Distance is taken one bit wider than the counter so it cannot wrap.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            diff[k]  = (cnt_x >= per[k]) ? (cnt_x - per[k])
                                         : (per[k] - cnt_x);
            hit_k[k] = (diff[k] <= tol_x);
        end
    end

    always_comb begin
        hit = |hit_k;
        cls = RATE_FULL;
        priority case (1'b1)
            hit_k[0]: cls = RATE_FULL;
            hit_k[1]: cls = RATE_1HZ;
            hit_k[2]: cls = RATE_HALF;
            hit_k[3]: cls = RATE_QUARTER;
            default:  cls = RATE_FULL;
        endcase
    end

endmodule

// File: rtl/rate_decoder.sv
// Measures spacing between tick pulses, decodes it to a speed code,
// locks after repeated agreement and flags a silent tick source.
module rate_decoder
    import rate_pkg::*;
#(
    parameter int unsigned RATE_W     = RATE_W_DEF,
    parameter int unsigned PERIOD_0   = PERIOD_0_DEF,
    parameter int unsigned PERIOD_1   = PERIOD_1_DEF,
    parameter int unsigned PERIOD_2   = PERIOD_2_DEF,
    parameter int unsigned PERIOD_3   = PERIOD_3_DEF,
    parameter int unsigned TOL        = TOL_DEF,
    parameter int unsigned LOCK_COUNT = LOCK_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              tick,
    output logic [RATE_W-1:0] period,
    output logic              sample_stb,
    output logic [1:0]        rate_code,
    output logic              code_valid,
    output logic              timeout
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0] LOCK_V = MW'(LOCK_COUNT);
    localparam logic [RATE_W-1:0] TMO_V = RATE_W'(TIMEOUT);
    localparam logic [RATE_W-1:0] ONE_V = RATE_W'(1);

    state_e            state_q;
    logic [RATE_W-1:0] cnt_q;
    logic [RATE_W-1:0] period_q;
    logic [MW-1:0]     match_q;
    logic [MW-1:0]     match_d;
    logic [1:0]        last_q;
    logic [1:0]        code_q;
    logic              stb_q;
    logic              valid_q;
    logic              tout_q;
    logic              lock_d;
    logic              hit;
    logic [1:0]        cls;

    rate_classifier #(
        .RATE_W   (RATE_W),
        .PERIOD_0 (PERIOD_0),
        .PERIOD_1 (PERIOD_1),
        .PERIOD_2 (PERIOD_2),
        .PERIOD_3 (PERIOD_3),
        .TOL      (TOL)
    ) u_cls (
        .cnt (cnt_q),
        .hit (hit),
        .cls (cls)
    );

    always_comb begin
        match_d = '0;
        if (hit) begin
            if (cls != last_q)
                match_d = MW'(1);
            else if (match_q >= LOCK_V)
                match_d = LOCK_V;
            else
                match_d = match_q + MW'(1);
        end
        lock_d = (match_d >= LOCK_V);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            match_q  <= '0;
            last_q   <= RATE_FULL;
            code_q   <= RATE_FULL;
            stb_q    <= 1'b0;
            valid_q  <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            if (enable) begin
                unique case (state_q)
                    IDLE: begin
                        if (tick) begin
                            cnt_q   <= ONE_V;
                            state_q <= MEASURE;
                            tout_q  <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        // A tick on the timeout edge still counts as a sample.
                        if (tick) begin
                            period_q <= cnt_q;
                            cnt_q    <= ONE_V;
                            stb_q    <= 1'b1;
                            match_q  <= match_d;
                            valid_q  <= lock_d;
                            if (hit)
                                last_q <= cls;
                            if (lock_d)
                                code_q <= cls;
                        end else if (cnt_q == TMO_V) begin
                            state_q <= IDLE;
                            tout_q  <= 1'b1;
                            valid_q <= 1'b0;
                            match_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + ONE_V;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign period     = period_q;
    assign sample_stb = stb_q;
    assign rate_code  = code_q;
    assign code_valid = valid_q;
    assign timeout    = tout_q;

endmodule

// File: tb/tb_rate_decoder.sv
// Directed bench for rate_decoder with shortened periods
// (100/200/400, tolerance 4, timeout 1000).
module tb_rate_decoder;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        tick;
    logic [27:0] period;
    logic        sample_stb;
    logic [1:0]  rate_code;
    logic        code_valid;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    rate_decoder #(
        .PERIOD_1 (100),
        .PERIOD_2 (200),
        .PERIOD_3 (400),
        .TOL      (4),
        .TIMEOUT  (1000)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .tick       (tick),
        .period     (period),
        .sample_stb (sample_stb),
        .rate_code  (rate_code),
        .code_valid (code_valid),
        .timeout    (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         gap;
        logic       stb;
        int         per;
        logic       vld;
        logic [1:0] code;
    } row_t;

    row_t rows [17];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic t);
        tick = t;
        @(negedge clock);
        tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic chk_all(input string nm, input logic stb, input int per,
                           input logic vld, input logic [1:0] code,
                           input logic tmo);
        chk({nm, ".stb"},   int'(sample_stb), int'(stb));
        chk({nm, ".per"},   int'(period),     per);
        chk({nm, ".vld"},   int'(code_valid), int'(vld));
        chk({nm, ".code"},  int'(rate_code),  int'(code));
        chk({nm, ".tmo"},   int'(timeout),    int'(tmo));
    endtask

    initial begin
        rows[0]  = '{1,   1'b0, 0,   1'b0, 2'd0};
        rows[1]  = '{2,   1'b1, 2,   1'b0, 2'd0};
        rows[2]  = '{2,   1'b1, 2,   1'b1, 2'd0};
        rows[3]  = '{2,   1'b1, 2,   1'b1, 2'd0};
        rows[4]  = '{2,   1'b1, 2,   1'b1, 2'd0};
        rows[5]  = '{102, 1'b1, 102, 1'b0, 2'd0};
        rows[6]  = '{102, 1'b1, 102, 1'b1, 2'd1};
        rows[7]  = '{150, 1'b1, 150, 1'b0, 2'd1};
        rows[8]  = '{102, 1'b1, 102, 1'b0, 2'd1};
        rows[9]  = '{102, 1'b1, 102, 1'b1, 2'd1};
        rows[10] = '{400, 1'b1, 400, 1'b0, 2'd1};
        rows[11] = '{400, 1'b1, 400, 1'b1, 2'd3};
        rows[12] = '{200, 1'b1, 200, 1'b0, 2'd3};
        rows[13] = '{1,   1'b1, 1,   1'b0, 2'd3};
        rows[14] = '{1,   1'b1, 1,   1'b1, 2'd0};
        rows[15] = '{196, 1'b1, 196, 1'b0, 2'd0};
        rows[16] = '{205, 1'b1, 205, 1'b0, 2'd0};

        reset_n = 1'b0;
        enable  = 1'b1;
        tick    = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk_all("reset", 1'b0, 0, 1'b0, 2'd0, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int r = 0; r < 17; r++) begin
            if (rows[r].gap > 1) begin
                step(1'b0);
                chk($sformatf("row%0d.stb_low", r), int'(sample_stb), 0);
                idle(rows[r].gap - 2);
            end
            step(1'b1);
            chk_all($sformatf("row%0d", r), rows[r].stb, rows[r].per,
                    rows[r].vld, rows[r].code, 1'b0);
        end

        // Silence after one tick: loss flagged exactly 1000 cycles later.
        idle(49);
        step(1'b1);
        chk_all("pre_tmo", 1'b1, 50, 1'b0, 2'd0, 1'b0);
        idle(999);
        chk("tmo_early", int'(timeout), 0);
        idle(1);
        chk_all("tmo_hit", 1'b0, 50, 1'b0, 2'd0, 1'b1);
        idle(20);
        chk("tmo_sticky", int'(timeout), 1);
        step(1'b1);
        chk_all("tmo_rearm", 1'b0, 50, 1'b0, 2'd0, 1'b0);
        idle(99);
        step(1'b1);
        chk_all("tmo_after", 1'b1, 100, 1'b0, 2'd0, 1'b0);

        // Disabled window freezes the count and drops the tick inside it.
        idle(40);
        enable = 1'b0;
        idle(4);
        step(1'b1);
        chk("dis_tick_stb", int'(sample_stb), 0);
        chk("dis_tick_per", int'(period), 100);
        idle(5);
        enable = 1'b1;
        idle(59);
        step(1'b1);
        chk_all("dis_period", 1'b1, 100, 1'b1, 2'd1, 1'b0);

        // Asynchronous reset between edges while measuring.
        idle(30);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 0, 1'b0, 2'd0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1);
        chk_all("rst_first", 1'b0, 0, 1'b0, 2'd0, 1'b0);
        idle(1);
        step(1'b1);
        chk_all("rst_second", 1'b1, 2, 1'b0, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
